// File: rtl/operand_forward_if.sv
// Operand-forwarding bus: ID request, forwarding sources and EX/ME stage outputs.
interface operand_forward_if #(
    parameter int unsigned REG_WIDTH = 32,
    parameter int unsigned CNT_WIDTH = 16
) ();
    localparam int unsigned ADDR_W = 5;

    logic                 id_valid;
    logic                 id_wen;
    logic                 id_is_load;
    logic [ADDR_W-1:0]    id_rs1_addr;
    logic [ADDR_W-1:0]    id_rs2_addr;
    logic [ADDR_W-1:0]    id_rd_addr;
    logic                 id_rs1_sourced;
    logic                 id_rs2_sourced;
    logic [REG_WIDTH-1:0] rf_rs1_data;
    logic [REG_WIDTH-1:0] rf_rs2_data;
    logic [REG_WIDTH-1:0] ex_result;
    logic [REG_WIDTH-1:0] me_result;
    logic                 flush;
    logic                 hold;

    logic [REG_WIDTH-1:0] ex_opd1;
    logic [REG_WIDTH-1:0] ex_opd2;
    logic                 ex_valid;
    logic                 ex_wen;
    logic                 ex_is_load;
    logic [ADDR_W-1:0]    ex_rd_addr;
    logic                 me_valid;
    logic                 me_wen;
    logic [ADDR_W-1:0]    me_rd_addr;
    logic                 stall;
    logic [1:0]           fwd_sel1;
    logic [1:0]           fwd_sel2;
    logic [CNT_WIDTH-1:0] stall_count;

    modport master (
        output id_valid, id_wen, id_is_load, id_rs1_addr, id_rs2_addr, id_rd_addr,
               id_rs1_sourced, id_rs2_sourced, rf_rs1_data, rf_rs2_data,
               ex_result, me_result, flush, hold,
        input  ex_opd1, ex_opd2, ex_valid, ex_wen, ex_is_load, ex_rd_addr,
               me_valid, me_wen, me_rd_addr, stall, fwd_sel1, fwd_sel2, stall_count
    );

    modport slave (
        input  id_valid, id_wen, id_is_load, id_rs1_addr, id_rs2_addr, id_rd_addr,
               id_rs1_sourced, id_rs2_sourced, rf_rs1_data, rf_rs2_data,
               ex_result, me_result, flush, hold,
        output ex_opd1, ex_opd2, ex_valid, ex_wen, ex_is_load, ex_rd_addr,
               me_valid, me_wen, me_rd_addr, stall, fwd_sel1, fwd_sel2, stall_count
    );
endinterface

// File: rtl/operand_forward_unit.sv
// ID-stage operand forwarding with load-use stall detection and the ID->EX->ME control pipe.
module operand_forward_unit #(
    parameter int unsigned REG_WIDTH = 32,
    parameter int unsigned CNT_WIDTH = 16
) (
    input logic                clk,
    input logic                rst,
    operand_forward_if.slave   bus
);
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned SEL_W  = 2;

    localparam logic [SEL_W-1:0] SEL_RF   = 2'b00;
    localparam logic [SEL_W-1:0] SEL_EX   = 2'b01;
    localparam logic [SEL_W-1:0] SEL_ME   = 2'b10;
    localparam logic [SEL_W-1:0] SEL_ZERO = 2'b11;

    typedef enum logic {RUN, LU_STALL} state_t;
    state_t state;

    logic                 ex_hit1, ex_hit2, me_hit1, me_hit2;
    logic                 lu_hazard, stall_now;
    logic [SEL_W-1:0]     sel1, sel2;
    logic [REG_WIDTH-1:0] opd1, opd2;

    // Load results are not available in EX, so only non-load EX writers may forward.
    assign ex_hit1 = bus.ex_valid && bus.ex_wen && !bus.ex_is_load && bus.id_rs1_sourced &&
                     (bus.ex_rd_addr == bus.id_rs1_addr) && (bus.id_rs1_addr != ADDR_W'(0));
    assign ex_hit2 = bus.ex_valid && bus.ex_wen && !bus.ex_is_load && bus.id_rs2_sourced &&
                     (bus.ex_rd_addr == bus.id_rs2_addr) && (bus.id_rs2_addr != ADDR_W'(0));
    assign me_hit1 = bus.me_valid && bus.me_wen && bus.id_rs1_sourced &&
                     (bus.me_rd_addr == bus.id_rs1_addr) && (bus.id_rs1_addr != ADDR_W'(0));
    assign me_hit2 = bus.me_valid && bus.me_wen && bus.id_rs2_sourced &&
                     (bus.me_rd_addr == bus.id_rs2_addr) && (bus.id_rs2_addr != ADDR_W'(0));

    assign lu_hazard = bus.id_valid && bus.ex_valid && bus.ex_is_load && bus.ex_wen &&
                       (bus.ex_rd_addr != ADDR_W'(0)) &&
                       ((bus.id_rs1_sourced && (bus.ex_rd_addr == bus.id_rs1_addr)) ||
                        (bus.id_rs2_sourced && (bus.ex_rd_addr == bus.id_rs2_addr)));

    // In LU_STALL the load has moved to ME and is forwarded from there.
    assign stall_now = (state == RUN) && lu_hazard;

    // Operand source priority: unsourced -> regfile, x0 -> zero, then youngest producer.
    always_comb begin
        sel1 = SEL_RF;
        sel2 = SEL_RF;
        if (bus.id_rs1_sourced) begin
            if (bus.id_rs1_addr == ADDR_W'(0)) sel1 = SEL_ZERO;
            else if (ex_hit1)                  sel1 = SEL_EX;
            else if (me_hit1)                  sel1 = SEL_ME;
        end
        if (bus.id_rs2_sourced) begin
            if (bus.id_rs2_addr == ADDR_W'(0)) sel2 = SEL_ZERO;
            else if (ex_hit2)                  sel2 = SEL_EX;
            else if (me_hit2)                  sel2 = SEL_ME;
        end
    end

    always_comb begin
        opd1 = bus.rf_rs1_data;
        opd2 = bus.rf_rs2_data;
        case (sel1)
            SEL_EX:   opd1 = bus.ex_result;
            SEL_ME:   opd1 = bus.me_result;
            SEL_ZERO: opd1 = '0;
            default:  opd1 = bus.rf_rs1_data;
        endcase
        case (sel2)
            SEL_EX:   opd2 = bus.ex_result;
            SEL_ME:   opd2 = bus.me_result;
            SEL_ZERO: opd2 = '0;
            default:  opd2 = bus.rf_rs2_data;
        endcase
    end

    assign bus.fwd_sel1 = sel1;
    assign bus.fwd_sel2 = sel2;
    assign bus.stall    = stall_now;

    // Pipeline registers, stall counter and RUN/LU_STALL state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= RUN;
            bus.ex_valid    <= 1'b0;
            bus.ex_wen      <= 1'b0;
            bus.ex_is_load  <= 1'b0;
            bus.ex_rd_addr  <= '0;
            bus.ex_opd1     <= '0;
            bus.ex_opd2     <= '0;
            bus.me_valid    <= 1'b0;
            bus.me_wen      <= 1'b0;
            bus.me_rd_addr  <= '0;
            bus.stall_count <= '0;
        end else if (!bus.hold) begin
            bus.me_valid   <= bus.ex_valid;
            bus.me_wen     <= bus.ex_wen;
            bus.me_rd_addr <= bus.ex_rd_addr;

            if (bus.flush || stall_now) begin
                bus.ex_valid   <= 1'b0;
                bus.ex_wen     <= 1'b0;
                bus.ex_is_load <= 1'b0;
                bus.ex_rd_addr <= '0;
            end else begin
                bus.ex_valid   <= bus.id_valid;
                bus.ex_wen     <= bus.id_valid && bus.id_wen;
                bus.ex_is_load <= bus.id_valid && bus.id_is_load;
                bus.ex_rd_addr <= bus.id_rd_addr;
                bus.ex_opd1    <= opd1;
                bus.ex_opd2    <= opd2;
            end

            if (stall_now && !bus.flush && (bus.stall_count != {CNT_WIDTH{1'b1}}))
                bus.stall_count <= bus.stall_count + CNT_WIDTH'(1);

            if (bus.flush) begin
                state <= RUN;
            end else begin
                case (state)
                    RUN:      if (lu_hazard) state <= LU_STALL;
                    LU_STALL: state <= RUN;
                    default:  state <= RUN;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_operand_forward_unit.sv
// Vector table plus scoreboard bench for operand_forward_unit.
module tb_operand_forward_unit;
    localparam int unsigned RW = 32;
    localparam int unsigned CW = 4;
    localparam int unsigned NROWS = 19;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    operand_forward_if #(.REG_WIDTH(RW), .CNT_WIDTH(CW)) bus ();
    operand_forward_unit #(.REG_WIDTH(RW), .CNT_WIDTH(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // ctl = {valid, wen, is_load}; src = {rs1_sourced, rs2_sourced}; hf = {hold, flush}
    // chk = {check operands, check stall_count}
    typedef struct {
        logic [2:0]    ctl;
        logic [4:0]    rs1, rs2, rd;
        logic [1:0]    src;
        logic [RW-1:0] rf1, rf2, exr, mer;
        logic [1:0]    hf;
        logic [1:0]    sel1, sel2;
        logic          stall;
        logic          nv;
        logic [RW-1:0] o1, o2;
        logic [CW-1:0] cnt;
        logic [1:0]    chk;
    } row_t;

    typedef struct {
        string         nm;
        logic          nv;
        logic [RW-1:0] o1, o2;
        logic [CW-1:0] cnt;
        logic [1:0]    chk;
    } exp_t;

    row_t rows [NROWS];
    exp_t sb [$];

    task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input row_t r);
        {bus.id_valid, bus.id_wen, bus.id_is_load} = r.ctl;
        bus.id_rs1_addr = r.rs1;
        bus.id_rs2_addr = r.rs2;
        bus.id_rd_addr  = r.rd;
        {bus.id_rs1_sourced, bus.id_rs2_sourced} = r.src;
        bus.rf_rs1_data = r.rf1;
        bus.rf_rs2_data = r.rf2;
        bus.ex_result   = r.exr;
        bus.me_result   = r.mer;
        {bus.hold, bus.flush} = r.hf;
    endtask

    // Drive one row, check combinational outputs, then check registered outputs after the edge.
    task automatic step(input row_t r, input string nm);
        exp_t e;
        drive(r);
        #1;
        chk({nm, ".fwd_sel1"}, RW'(bus.fwd_sel1), RW'(r.sel1));
        chk({nm, ".fwd_sel2"}, RW'(bus.fwd_sel2), RW'(r.sel2));
        chk({nm, ".stall"}, RW'(bus.stall), RW'(r.stall));
        e.nm = nm; e.nv = r.nv; e.o1 = r.o1; e.o2 = r.o2; e.cnt = r.cnt; e.chk = r.chk;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.nm, ".ex_valid"}, RW'(bus.ex_valid), RW'(e.nv));
        if (e.chk[1]) begin
            chk({e.nm, ".ex_opd1"}, bus.ex_opd1, e.o1);
            chk({e.nm, ".ex_opd2"}, bus.ex_opd2, e.o2);
        end
        if (e.chk[0]) chk({e.nm, ".stall_count"}, RW'(bus.stall_count), RW'(e.cnt));
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, ".ex_valid"},    RW'(bus.ex_valid),    '0);
        chk({nm, ".ex_wen"},      RW'(bus.ex_wen),      '0);
        chk({nm, ".ex_is_load"},  RW'(bus.ex_is_load),  '0);
        chk({nm, ".ex_rd_addr"},  RW'(bus.ex_rd_addr),  '0);
        chk({nm, ".ex_opd1"},     bus.ex_opd1,          '0);
        chk({nm, ".ex_opd2"},     bus.ex_opd2,          '0);
        chk({nm, ".me_valid"},    RW'(bus.me_valid),    '0);
        chk({nm, ".me_wen"},      RW'(bus.me_wen),      '0);
        chk({nm, ".me_rd_addr"},  RW'(bus.me_rd_addr),  '0);
        chk({nm, ".stall_count"}, RW'(bus.stall_count), '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    row_t idle, ld6, use6;

    initial begin
        //            ctl     rs1   rs2    rd     src    rf1        rf2        exr        mer        hf     sel1   sel2   st    nv    o1         o2         cnt   chk
        rows[0]  = '{3'b110, 5'd1, 5'd2,  5'd5,  2'b11, 32'hA,     32'hB,     32'h0,     32'h0,     2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 32'hA,     32'hB,     4'd0, 2'b11};
        rows[1]  = '{3'b110, 5'd5, 5'd3,  5'd8,  2'b11, 32'h55,    32'h33,    32'h11,    32'h99,    2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 32'h11,    32'h33,    4'd0, 2'b11};
        rows[2]  = '{3'b110, 5'd1, 5'd2,  5'd7,  2'b11, 32'h1,     32'h2,     32'h0,     32'h0,     2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 32'h1,     32'h2,     4'd0, 2'b11};
        rows[3]  = '{3'b110, 5'd9, 5'd10, 5'd7,  2'b11, 32'h3,     32'h4,     32'h0,     32'h0,     2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 32'h3,     32'h4,     4'd0, 2'b11};
        rows[4]  = '{3'b110, 5'd7, 5'd7,  5'd11, 2'b11, 32'h77,    32'h77,    32'h1,     32'h2,     2'b00, 2'b01, 2'b01, 1'b0, 1'b1, 32'h1,     32'h1,     4'd0, 2'b11};
        rows[5]  = '{3'b110, 5'd7, 5'd11, 5'd12, 2'b11, 32'h0,     32'h0,     32'h5,     32'h2,     2'b00, 2'b10, 2'b01, 1'b0, 1'b1, 32'h2,     32'h5,     4'd0, 2'b11};
        rows[6]  = '{3'b110, 5'd12,5'd11, 5'd0,  2'b00, 32'hAA,    32'hBB,    32'h0,     32'h0,     2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 32'hAA,    32'hBB,    4'd0, 2'b11};
        rows[7]  = '{3'b111, 5'd0, 5'd0,  5'd0,  2'b11, 32'hDEAD,  32'hBEEF,  32'h123,   32'h0,     2'b00, 2'b11, 2'b11, 1'b0, 1'b1, 32'h0,     32'h0,     4'd0, 2'b11};
        rows[8]  = '{3'b110, 5'd0, 5'd2,  5'd13, 2'b11, 32'h0,     32'h22,    32'h0,     32'h0,     2'b00, 2'b11, 2'b00, 1'b0, 1'b1, 32'h0,     32'h22,    4'd0, 2'b11};
        rows[9]  = '{3'b111, 5'd1, 5'd0,  5'd6,  2'b10, 32'h100,   32'h0,     32'h0,     32'h0,     2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 32'h100,   32'h0,     4'd0, 2'b11};
        rows[10] = '{3'b110, 5'd3, 5'd6,  5'd14, 2'b11, 32'h3,     32'h66,    32'h0,     32'h0,     2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0,     32'h0,     4'd1, 2'b01};
        rows[11] = '{3'b110, 5'd3, 5'd6,  5'd14, 2'b11, 32'h3,     32'h66,    32'h0,     32'hCAFE,  2'b00, 2'b00, 2'b10, 1'b0, 1'b1, 32'h3,     32'hCAFE,  4'd1, 2'b11};
        rows[12] = '{3'b000, 5'd0, 5'd0,  5'd0,  2'b00, 32'h0,     32'h0,     32'h0,     32'h0,     2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,     32'h0,     4'd1, 2'b01};
        rows[13] = '{3'b111, 5'd1, 5'd2,  5'd6,  2'b00, 32'h13,    32'h31,    32'h0,     32'h0,     2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 32'h13,    32'h31,    4'd1, 2'b11};
        rows[14] = '{3'b110, 5'd6, 5'd0,  5'd15, 2'b10, 32'h0,     32'h0,     32'h0,     32'h0,     2'b10, 2'b00, 2'b00, 1'b1, 1'b1, 32'h13,    32'h31,    4'd1, 2'b11};
        rows[15] = rows[14];
        rows[16] = rows[14];
        rows[17] = '{3'b110, 5'd6, 5'd0,  5'd15, 2'b10, 32'h0,     32'h0,     32'h0,     32'h0,     2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0,     32'h0,     4'd0, 2'b00};
        rows[18] = '{3'b110, 5'd6, 5'd0,  5'd15, 2'b10, 32'h0,     32'h0,     32'h0,     32'h600,   2'b00, 2'b10, 2'b00, 1'b0, 1'b1, 32'h600,   32'h0,     4'd0, 2'b10};

        idle = rows[12];
        ld6  = '{3'b111, 5'd0, 5'd0, 5'd6, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00,
                 2'b00, 2'b00, 1'b0, 1'b1, 32'h0, 32'h0, 4'd0, 2'b00};
        use6 = '{3'b110, 5'd6, 5'd1, 5'd9, 2'b10, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00,
                 2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0, 4'd0, 2'b01};

        drive(idle);
        do_reset();
        check_reset_state("reset");
        chk("reset.stall", RW'(bus.stall), '0);

        for (int i = 0; i < int'(NROWS); i++) step(rows[i], $sformatf("row%0d", i));

        // Saturating stall counter: repeated load-use pairs past the all-ones value.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            row_t u, r;
            step(ld6, $sformatf("sat%0d.load", i));
            u = use6;
            u.cnt = (i + 1 >= 15) ? 4'hF : CW'(i + 1);
            step(u, $sformatf("sat%0d.stall", i));
            r = use6;
            r.sel1 = 2'b10; r.stall = 1'b0; r.nv = 1'b1; r.chk = 2'b01; r.cnt = u.cnt;
            step(r, $sformatf("sat%0d.resume", i));
        end

        // Reset in the middle of a stall wins over hold and flush.
        step(ld6, "rstmid.load");
        drive(use6);
        bus.hold  = 1'b1;
        bus.flush = 1'b1;
        #1;
        chk("rstmid.stall_before", RW'(bus.stall), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.hold  = 1'b0;
        bus.flush = 1'b0;
        #1;
        check_reset_state("rstmid");
        chk("rstmid.stall_after", RW'(bus.stall), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/operand_forward_unit.md
OPERAND_FORWARD_UNIT -- requirements
Module: operand_forward_unit

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32, setting the operand/result data width.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, setting the stall-counter width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports id_valid, id_wen, id_is_load  input  1 each: ID instruction valid, writes rd, is a load.
REQ-006 SHALL have ports id_rs1_addr, id_rs2_addr, id_rd_addr  input  5 each: ID register addresses.
REQ-007 SHALL have ports id_rs1_sourced, id_rs2_sourced  input  1 each: ID actually reads rs1/rs2.
REQ-008 SHALL have ports rf_rs1_data, rf_rs2_data  input  REG_WIDTH each: register-file read data.
REQ-009 SHALL have ports ex_result, me_result  input  REG_WIDTH each: EX ALU result and ME result (load data for loads).
REQ-010 SHALL have ports flush, hold  input  1 each: kill the ID instruction; freeze the unit (external memory busy).
REQ-011 SHALL have ports ex_opd1, ex_opd2  output  REG_WIDTH each: registered operands for EX.
REQ-012 SHALL have ports ex_valid, ex_wen, ex_is_load  output  1 each, and ex_rd_addr  output  5: EX-stage control.
REQ-013 SHALL have ports me_valid, me_wen  output  1 each, and me_rd_addr  output  5: ME-stage control.
REQ-014 SHALL have port stall  output  1: ID/IF must not advance this cycle.
REQ-015 SHALL have ports fwd_sel1, fwd_sel2  output  2 each: 00 regfile, 01 EX, 10 ME, 11 zero (x0).
REQ-016 SHALL have port stall_count  output  CNT_WIDTH: saturating count of load-use stall cycles.

Function
REQ-017 SHALL select each operand combinationally: x0 -> zero; else EX match -> ex_result; else ME match -> me_result; else regfile.
REQ-018 SHALL define EX match as ex_valid & ex_wen & !ex_is_load & ex_rd_addr==rs & rs!=0 & rs_sourced; ME match as me_valid & me_wen & me_rd_addr==rs & rs!=0 & rs_sourced.
REQ-019 SHALL treat an unsourced operand as regfile (fwd_sel 00) regardless of address matches.
REQ-020 SHALL detect load-use hazard when id_valid & ex_valid & ex_is_load & ex_wen & ex_rd_addr!=0 and ex_rd_addr equals a sourced rs.
REQ-021 SHALL implement FSM RUN/LU_STALL: RUN + hazard & !hold & !flush -> LU_STALL; LU_STALL -> RUN next non-held edge; flush from any state -> RUN.
REQ-022 SHALL assert stall combinationally whenever the hazard condition holds in RUN; stall SHALL be 0 in LU_STALL (load is then in ME and forwarded).
REQ-023 SHALL, on a non-held edge without stall/flush, load ID into EX (valid, wen, is_load, rd, selected operands) and EX into ME; latency ID->EX one cycle.
REQ-024 SHALL, on a stall edge, insert a bubble in EX (ex_valid=0, ex_wen=0, ex_is_load=0) while EX advances to ME.
REQ-025 SHALL, on a flush edge, insert a bubble in EX and advance EX to ME; flush overrides stall.
REQ-026 SHALL, while hold=1, keep all registers, FSM state and stall_count unchanged; stall output still reflects the hazard.
REQ-027 SHALL increment stall_count on each stall edge not held, saturating at all-ones (no wrap).
REQ-028 SHALL treat id_valid=0 as a bubble: ex_valid=0, ex_wen=0 on the next edge.

Reset
REQ-029 SHALL on rst set ex_valid, ex_wen, ex_is_load, me_valid, me_wen to 0, ex_rd_addr, me_rd_addr to 0, ex_opd1/2 to 0, stall_count to 0, FSM to RUN.
REQ-030 SHALL give rst priority over hold and flush; reset mid-stall returns to RUN with stall=0 next cycle.

Verification
REQ-031 SHALL pass: ADD x5 (ex_result=0x11) then ADD rs1=x5 -> fwd_sel1=01, ex_opd1=0x11 next cycle.
REQ-032 SHALL pass: LW x6 then ADD rs2=x6 -> stall=1 one cycle, EX bubble, then fwd_sel2=10, ex_opd2=me_result=0xCAFE, stall_count=1.
REQ-033 SHALL pass: EX and ME both write x7 (0x1, 0x2), ID reads x7 -> fwd_sel=01, operand 0x1.
REQ-034 SHALL pass: ID reads x0 with EX writing x0 -> fwd_sel=11, operand 0; LW x0 then use x0 -> no stall.
REQ-035 SHALL pass: hold=1 for 3 cycles during a hazard -> registers and stall_count frozen; flush during stall -> RUN, EX bubble; stall_count preset to 0xFFFF stays 0xFFFF.
